acc_fifo: RTL and testbench
===========================

# acc_fifo

Synchronous 128-bit FIFO at the accelerator end of the data/control router's put/get interface. One instance per direction per accelerator (to_fft, from_fft, to_fir, from_fir, to_iir, from_iir). The producer side issues `put_req` with data and the consumer side issues `get_req`. The block returns the `full`/`empty` status that the router uses to pause address generation.

## Interface
- `WIDTH`, default 128: data word width.
- `DEPTH`, default 16: number of entries; must be a power of 2, minimum 2.
- `AW`, default 4: pointer width, log2(`DEPTH`).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `put_req`  in  1  write request; qualifies `put_data` for one cycle.
- `put_data`  in  `WIDTH`  write data.
- `get_req`  in  1  read request.
- `get_data`  out  `WIDTH`  registered read data.
- `get_valid`  out  1  one-cycle pulse; `get_data` is valid.
- `full`  out  1  occupancy == `DEPTH`.
- `empty`  out  1  occupancy == 0.
- `ovf_err`  out  1  sticky overflow flag (see Configuration).
- `udf_err`  out  1  sticky underflow flag (see Configuration).

## Operation
- Storage is a `DEPTH` x `WIDTH` register array with write pointer `wp`, read pointer `rp` (both `AW` bits) and occupancy counter `cnt` (`AW`+1 bits).
- Put is accepted iff `put_req` && !`full`:
  - `mem[wp]` <= `put_data`;
  - `wp` <= `wp`+1, wrapping `DEPTH`-1 -> 0.
- Get is accepted iff `get_req` && !`empty`:
  - `get_data` <= `mem[rp]`;
  - `rp` <= `rp`+1, wrapping;
  - `get_valid` <= 1.
  - Otherwise `get_valid` <= 0 and `get_data` holds its last value.
- Counter update:
  - `cnt` +1 on put only, -1 on get only;
  - unchanged when both or neither are accepted.
- Acceptance is evaluated against the current `full`/`empty`:
  - When full, a put is rejected even if a get is accepted in the same cycle.
  - When empty, a get is rejected even if a put is accepted in the same cycle. No write-through bypass.
- Rejected requests leave all state unchanged, apart from the error flags.
- `full` and `empty` are registered, computed from the next-state `cnt`, so they are exact in the cycle after an update.
- Reset (asynchronous, any time, including mid-burst):
  - `wp`=`rp`=0, `cnt`=0;
  - `empty`=1, `full`=0;
  - `get_valid`=0, `get_data`=0;
  - `ovf_err`=`udf_err`=0.
  - Array contents are not reset. Data in flight is discarded.

## Timing
- Put-to-visible: data put at edge N is gettable at edge N+1 (`empty` deasserts after edge N).
- Get latency: `get_req` sampled at edge N -> `get_data`/`get_valid` valid after edge N, for one cycle.
- Back-to-back puts and gets at full rate, 1 per cycle each, are sustained indefinitely when 0 < `cnt` < `DEPTH`.
- `full` asserts the cycle after the `DEPTH`-th unmatched put; `empty` asserts the cycle after the last unmatched get.
- No combinational path from any input to any output.

## Configuration
- Macro: `ACC_FIFO_ERR_EN`.
- Defined:
  - `ovf_err` sets on any cycle with `put_req` && `full`.
  - `udf_err` sets on any cycle with `get_req` && `empty`.
  - Both are sticky until reset and registered, so they are visible after the offending edge.
- Undefined: `ovf_err` and `udf_err` are tied to 0 and no error logic is synthesized. The ports remain present for integration compatibility.
- FIFO data behaviour is identical in both builds.

## Test plan
- Reset:
  - Stimulus: assert `reset` asynchronously between edges, mid-stream.
  - Required: outputs immediately read `empty`=1, `full`=0, `get_valid`=0, `get_data`=0.
  - Required: after release, a get is rejected (`get_valid` stays 0).
- Fill/drain ordering (`DEPTH`=16):
  - Stimulus: put 0x1..0x10, one per cycle.
  - Required: `full`=1 after the 16th put.
  - Stimulus: then get 16 times.
  - Required: `get_data` returns 0x1..0x10 in order, `get_valid` high 16 cycles, then `empty`=1.
- Overflow:
  - Stimulus: with the FIFO full, put 0xDEAD.
  - Required: rejected, `cnt` unchanged; the next 16 gets never return 0xDEAD.
  - Required: `ovf_err`=1 with `ACC_FIFO_ERR_EN` defined, 0 without.
- Underflow with simultaneous put:
  - Stimulus: when empty, `put_req` (0xA5) and `get_req` in the same cycle.
  - Required: get rejected, `get_valid`=0, `empty`=0 next cycle.
  - Required: `udf_err`=1 if the macro is defined.
  - Stimulus: next get.
  - Required: returns 0xA5.
- Simultaneous put/get at mid occupancy:
  - Stimulus: at `cnt`=8, issue 100 cycles of concurrent put and get.
  - Required: `cnt` stays 8, `full`=`empty`=0 throughout, data order preserved across pointer wrap.
- Full plus concurrent get:
  - Stimulus: when full, put and get in the same cycle.
  - Required: get accepted, put dropped, `full`=0 next cycle, occupancy 15.

Source files
------------

// File: rtl/acc_fifo.sv
// acc_fifo: DEPTH x WIDTH synchronous FIFO between the router put/get port and an accelerator.
// Define ACC_FIFO_ERR_EN to build the sticky overflow/underflow flags; otherwise they are tied low.
module acc_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             put_req_i,
  input  logic [WIDTH-1:0] put_data_i,
  input  logic             get_req_i,
  output logic [WIDTH-1:0] get_data_o,
  output logic             get_valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_err_o,
  output logic             udf_err_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic [WIDTH-1:0] get_data_q, get_data_d;
  logic             get_valid_q, get_valid_d;
  logic             put_ok, get_ok;

  // Acceptance uses the registered flags, so a full FIFO drops a put even
  // when a get drains it in the same cycle, and there is no write-through.
  always_comb begin
    put_ok      = put_req_i && !full_q;
    get_ok      = get_req_i && !empty_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    cnt_d       = cnt_q;
    get_data_d  = get_data_q;
    get_valid_d = get_ok;
    if (put_ok) wp_d = wp_q + AW'(1);
    if (get_ok) begin
      rp_d       = rp_q + AW'(1);
      get_data_d = mem_q[rp_q];
    end
    case ({put_ok, get_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == FULL_CNT);
    empty_d = (cnt_d == '0);
  end

  // NOTE: the storage array has no reset; only pointers and flags define its contents.
  always_ff @(posedge clk_i) begin
    if (put_ok) mem_q[wp_q] <= put_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      get_data_q  <= '0;
      get_valid_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      get_data_q  <= get_data_d;
      get_valid_q <= get_valid_d;
    end
  end

  assign get_data_o  = get_data_q;
  assign get_valid_o = get_valid_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

`ifdef ACC_FIFO_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (put_req_i & full_q);
    udf_d = udf_q | (get_req_i & empty_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_err_o = ovf_q;
  assign udf_err_o = udf_q;
`else
  assign ovf_err_o = 1'b0;
  assign udf_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_acc_fifo.sv
// Self-checking bench for acc_fifo (DEPTH=16, WIDTH=128): vector table plus
// hand-written fill/drain, overflow, full+get, mid-occupancy and async reset sequences.
module tb_acc_fifo;

  localparam int WIDTH = 128;
  localparam int DEPTH = 16;
`ifdef ACC_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             put_req_i;
  logic [WIDTH-1:0] put_data_i;
  logic             get_req_i;
  logic [WIDTH-1:0] get_data_o;
  logic             get_valid_o, full_o, empty_o, ovf_err_o, udf_err_o;

  int checks = 0;
  int errors = 0;

  acc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(4)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .put_req_i  (put_req_i),
    .put_data_i (put_data_i),
    .get_req_i  (get_req_i),
    .get_data_o (get_data_o),
    .get_valid_o(get_valid_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .ovf_err_o  (ovf_err_o),
    .udf_err_o  (udf_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic             put;
    logic [WIDTH-1:0] data;
    logic             get;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_full;
    logic             exp_empty;
  } vec_t;

  vec_t vecs [7];
  logic [WIDTH-1:0] model_q [$];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests and sample outputs 1 time unit after the edge.
  task automatic cycle(input logic put, input logic [WIDTH-1:0] data, input logic get);
    put_req_i  = put;
    put_data_i = data;
    get_req_i  = get;
    @(posedge clk_i);
    #1;
    put_req_i = 1'b0;
    get_req_i = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_empty"}, WIDTH'(empty_o), WIDTH'(1'b1));
    check({tag, "_full"},  WIDTH'(full_o), '0);
    check({tag, "_valid"}, WIDTH'(get_valid_o), '0);
    check({tag, "_data"},  get_data_o, '0);
    check({tag, "_ovf"},   WIDTH'(ovf_err_o), '0);
    check({tag, "_udf"},   WIDTH'(udf_err_o), '0);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check_idle_reset("reset_async");
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i    = 1'b1;
    put_req_i  = 1'b0;
    put_data_i = '0;
    get_req_i  = 1'b0;

    vecs[0] = '{1'b1, 128'h11, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 128'h0,  1'b1, 1'b1, 128'h11, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 128'h0,  1'b1, 1'b0, 128'h11, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 128'hA5, 1'b1, 1'b0, 128'h11, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 128'h33, 1'b1, 1'b1, 128'hA5, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 128'h0,  1'b0, 1'b0, 128'hA5, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 128'h0,  1'b1, 1'b1, 128'h33, 1'b0, 1'b1};

    #12;
    check_idle_reset("reset_init");
    @(negedge clk_i);
    reset_i = 1'b0;

    // Table: single-entry traffic, underflow with simultaneous put, held data.
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].put, vecs[i].data, vecs[i].get);
      check($sformatf("vec%0d_valid", i), WIDTH'(get_valid_o), WIDTH'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i),  get_data_o, vecs[i].exp_data);
      check($sformatf("vec%0d_full", i),  WIDTH'(full_o), WIDTH'(vecs[i].exp_full));
      check($sformatf("vec%0d_empty", i), WIDTH'(empty_o), WIDTH'(vecs[i].exp_empty));
    end
    check("udf_after_table", WIDTH'(udf_err_o), WIDTH'(ERR_EN));
    check("ovf_after_table", WIDTH'(ovf_err_o), '0);

    // Fill 0x1..0x10, overflow with 0xDEAD, drain in order.
    pulse_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b0);
      check($sformatf("fill%0d_full", i), WIDTH'(full_o), WIDTH'(i == DEPTH));
      check($sformatf("fill%0d_empty", i), WIDTH'(empty_o), '0);
    end
    cycle(1'b1, 128'hDEAD, 1'b0);
    check("ovf_full", WIDTH'(full_o), WIDTH'(1'b1));
    check("ovf_flag", WIDTH'(ovf_err_o), WIDTH'(ERR_EN));
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      check($sformatf("drain%0d_valid", i), WIDTH'(get_valid_o), WIDTH'(1'b1));
      check($sformatf("drain%0d_data", i), get_data_o, WIDTH'(i));
      check($sformatf("drain%0d_empty", i), WIDTH'(empty_o), WIDTH'(i == DEPTH));
      check($sformatf("drain%0d_full", i), WIDTH'(full_o), '0);
    end
    cycle(1'b0, '0, 1'b1);
    check("drain_extra_valid", WIDTH'(get_valid_o), '0);

    // Full plus concurrent put/get: get wins, put dropped, 15 remain.
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(32'h100 + i), 1'b0);
    check("fullget_pre_full", WIDTH'(full_o), WIDTH'(1'b1));
    cycle(1'b1, 128'hBEEF, 1'b1);
    check("fullget_valid", WIDTH'(get_valid_o), WIDTH'(1'b1));
    check("fullget_data", get_data_o, 128'h100);
    check("fullget_full", WIDTH'(full_o), '0);
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      check($sformatf("fullget_drain%0d", i), get_data_o, WIDTH'(32'h100 + i));
    end
    check("fullget_empty", WIDTH'(empty_o), WIDTH'(1'b1));
    cycle(1'b0, '0, 1'b1);
    check("fullget_noextra_valid", WIDTH'(get_valid_o), '0);

    // Mid-occupancy streaming across pointer wrap against a queue model.
    pulse_reset();
    model_q.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, WIDTH'(32'h200 + i), 1'b0);
      model_q.push_back(WIDTH'(32'h200 + i));
    end
    for (int k = 0; k < 100; k++) begin
      logic [WIDTH-1:0] exp_d;
      exp_d = model_q.pop_front();
      model_q.push_back({96'h0, 32'h3000 + k});
      cycle(1'b1, {96'h0, 32'h3000 + k}, 1'b1);
      check($sformatf("stream%0d_valid", k), WIDTH'(get_valid_o), WIDTH'(1'b1));
      check($sformatf("stream%0d_data", k), get_data_o, exp_d);
      check($sformatf("stream%0d_flags", k), WIDTH'({full_o, empty_o}), '0);
    end

    // Async reset mid-stream, then a get must be rejected.
    cycle(1'b0, '0, 1'b1);
    check("prereset_valid", WIDTH'(get_valid_o), WIDTH'(1'b1));
    pulse_reset();
    cycle(1'b0, '0, 1'b1);
    check("postreset_get_valid", WIDTH'(get_valid_o), '0);
    check("postreset_data", get_data_o, '0);
    check("postreset_empty", WIDTH'(empty_o), WIDTH'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
